ball_collision_detector: RTL and testbench
==========================================

Name: ball_collision_detector

Overview:
- Consumes ball coordinates from the ball controller and paddle positions; produces the vCol/hCol direction-flip pulses that drive it.
- Also detects goals and requests a re-serve.
- Sits between the ball controller, the paddle controllers and the VGA renderer on the 640x480 pong field.

Parameters:
- H_RES, 640, horizontal field width in pixels.
- V_RES, 480, vertical field height in pixels.
- BALL_SIZE, 8, ball square side in pixels.
- PAD_W, 8, paddle width in pixels.
- PAD_H, 64, paddle height in pixels.
- PAD_L_X, 16, left paddle left-edge x.
- PAD_R_X, 616, right paddle left-edge x.
- COOLDOWN, 4, enable ticks during which a repeat flip on the same axis is suppressed.
- SERVE_TICKS, 60, enable ticks spent in SERVE before play resumes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  game-tick strobe, one clk wide; same strobe the ball controller counts on.
- xCoord  in  10  ball left-edge x.
- yCoord  in  9  ball top-edge y.
- padLY  in  9  left paddle top y.
- padRY  in  9  right paddle top y.
- vCol  out  1  vertical-direction flip pulse.
- hCol  out  1  horizontal-direction flip pulse.
- scoreL  out  1  left player scored, pulse.
- scoreR  out  1  right player scored, pulse.
- serve  out  1  held high during SERVE; ball controller reset source.

Behaviour:
- Reset (reset==0 at posedge clk): vCol=hCol=scoreL=scoreR=0, serve=1, state=SERVE, serve counter=0, both cooldown counters=0.
- All outputs are registered. Detection samples inputs only on cycles with enable=1. Pulses assert on the clk edge after that sample, for exactly 1 clk. An enable strobe with no detection leaves pulses at 0.
- States: SERVE, PLAY.
- SERVE:
  - serve=1; no vCol/hCol/score pulses.
  - Counts enable ticks. After SERVE_TICKS ticks: serve=0, state goes to PLAY.
- PLAY, wall hit:
  - Condition: yCoord==0 or yCoord>=V_RES-BALL_SIZE.
  - If vCool==0: pulse vCol and load vCool=COOLDOWN.
- PLAY, paddle hit:
  - Left paddle condition: xCoord<=PAD_L_X+PAD_W, xCoord+BALL_SIZE>PAD_L_X, yCoord+BALL_SIZE>padLY, and yCoord<padLY+PAD_H.
  - Right paddle condition: same form, using PAD_R_X and padRY.
  - If either matches and hCool==0: pulse hCol and load hCool=COOLDOWN.
- PLAY, goal:
  - xCoord==0 with no left-paddle hit: pulse scoreR.
  - xCoord>=H_RES-BALL_SIZE with no right-paddle hit: pulse scoreL.
  - Either goal: state goes to SERVE with serve counter=0, serve=1 on the same edge as the score pulse, no hCol.
- Cooldowns: each decrements by 1 per enable tick while nonzero. Only the flip on that axis is suppressed; goal detection is never suppressed.
- Simultaneous events: corner hit gives vCol and hCol on the same edge. Goal takes priority over hCol; vCol may accompany a goal.
- Width rules: comparisons use 11-bit unsigned sums (no wrap). Coordinates above the field (x>=H_RES, y>=V_RES) are treated as the clamped boundary hit.
- enable=0: state, counters and outputs hold, except pulses, which return to 0.
- Reset mid-pulse: clears the pulse on that edge.

Optional Feature:
- Macro: SCORE_COUNT_EN.
- Defined:
  - Adds outputs scoreCntL[3:0] and scoreCntR[3:0], reset to 0.
  - Each increments on its score pulse and saturates at 9.
  - When either counter reaches 9, the FSM enters GAME_OVER: serve=1, no pulses, held until reset.
- Undefined: no counter ports and no GAME_OVER state; play cycles PLAY/SERVE indefinitely.

Test Plan:
- Release reset, strobe enable 60 times -> serve=1 for all 60 ticks, serve=0 after the 60th tick, state PLAY, no pulses.
- PLAY, y=0, x=300, enable -> vCol=1 for exactly 1 clk; y=0 held on the next 3 ticks -> no vCol; the 5th tick still at y=0 -> vCol again.
- PLAY, x=24, y=100, padLY=80, enable -> hCol pulse; same with padLY=200 -> no hCol.
- PLAY, x=0, y=300, padLY=0 -> scoreR pulse, serve=1 same edge, no hCol; 60 ticks later serve=0.
- PLAY, x=616, y=472, padRY=440 -> vCol and hCol on the same edge.
- Assert reset (0) during a vCol pulse cycle -> all outputs at reset values next edge; with SCORE_COUNT_EN, 9 right goals -> scoreCntR=9, GAME_OVER, further stimulus produces no pulses.

Source files
------------

// File: rtl/ball_collision_detector.sv
// rtl/ball_collision_detector.sv - wall/paddle/goal detection for the pong field.
// Optional SCORE_COUNT_EN adds per-player score counters and a GAME_OVER state.
module ball_collision_detector #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_L_X     = 16,
  parameter int PAD_R_X     = 616,
  parameter int COOLDOWN    = 4,
  parameter int SERVE_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] xCoord,
  input  logic [8:0] yCoord,
  input  logic [8:0] padLY,
  input  logic [8:0] padRY,
  output logic       vCol,
  output logic       hCol,
  output logic       scoreL,
  output logic       scoreR,
  output logic       serve
`ifdef SCORE_COUNT_EN
  ,
  output logic [3:0] scoreCntL,
  output logic [3:0] scoreCntR
`endif
);

  localparam int CW   = $clog2(COOLDOWN + 1);
  localparam int SC_W = $clog2(SERVE_TICKS);

  localparam logic [10:0]     BALL     = 11'(BALL_SIZE);
  localparam logic [10:0]     PAD_HT   = 11'(PAD_H);
  localparam logic [10:0]     L_X      = 11'(PAD_L_X);
  localparam logic [10:0]     L_XMAX   = 11'(PAD_L_X + PAD_W);
  localparam logic [10:0]     R_X      = 11'(PAD_R_X);
  localparam logic [10:0]     R_XMAX   = 11'(PAD_R_X + PAD_W);
  localparam logic [10:0]     X_GOAL   = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0]     Y_FLOOR  = 11'(V_RES - BALL_SIZE);
  localparam logic [CW-1:0]   COOL_LD  = CW'(COOLDOWN);
  localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_TICKS - 1);

`ifdef SCORE_COUNT_EN
  typedef enum logic [1:0] {SERVE, PLAY, GAME_OVER} state_t;
`else
  typedef enum logic {SERVE, PLAY} state_t;
`endif

  state_t          state;
  logic [SC_W-1:0] serve_cnt;
  logic [CW-1:0]   v_cool, h_cool;

  logic [10:0] x, y, ly, ry;
  logic        wall, hit_l, hit_r, goal_l, goal_r, v_fire, h_fire;
  logic [CW-1:0] v_next, h_next;

  assign x  = {1'b0, xCoord};
  assign y  = {2'b0, yCoord};
  assign ly = {2'b0, padLY};
  assign ry = {2'b0, padRY};

  // 11-bit sums never wrap; out-of-field coordinates land on the >= boundary tests
  assign wall   = (y == 11'd0) || (y >= Y_FLOOR);
  assign hit_l  = (x <= L_XMAX) && (x + BALL > L_X) && (y + BALL > ly) && (y < ly + PAD_HT);
  assign hit_r  = (x <= R_XMAX) && (x + BALL > R_X) && (y + BALL > ry) && (y < ry + PAD_HT);
  assign goal_r = (x == 11'd0) && !hit_l;
  assign goal_l = (x >= X_GOAL) && !hit_r;

  // The tick's own decrement is applied before the gate test, so a flip reopens
  // on the COOLDOWN-th tick after the one that loaded it.
  assign v_next = (v_cool != '0) ? v_cool - 1'b1 : '0;
  assign h_next = (h_cool != '0) ? h_cool - 1'b1 : '0;
  assign v_fire = wall && (v_next == '0);
  assign h_fire = (hit_l || hit_r) && (h_next == '0) && !(goal_l || goal_r);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SERVE;
      serve_cnt <= '0;
      v_cool    <= '0;
      h_cool    <= '0;
      vCol      <= 1'b0;
      hCol      <= 1'b0;
      scoreL    <= 1'b0;
      scoreR    <= 1'b0;
      serve     <= 1'b1;
`ifdef SCORE_COUNT_EN
      scoreCntL <= 4'd0;
      scoreCntR <= 4'd0;
`endif
    end else begin
      vCol   <= 1'b0;
      hCol   <= 1'b0;
      scoreL <= 1'b0;
      scoreR <= 1'b0;
      if (enable) begin
        v_cool <= v_next;
        h_cool <= h_next;
        case (state)
          SERVE: begin
            if (serve_cnt == SERVE_LAST) begin
              state     <= PLAY;
              serve     <= 1'b0;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
          PLAY: begin
            if (v_fire) begin
              vCol   <= 1'b1;
              v_cool <= COOL_LD;
            end
            if (goal_l || goal_r) begin
              scoreL    <= goal_l;
              scoreR    <= goal_r;
              state     <= SERVE;
              serve     <= 1'b1;
              serve_cnt <= '0;
`ifdef SCORE_COUNT_EN
              if (goal_l && scoreCntL != 4'd9) scoreCntL <= scoreCntL + 4'd1;
              if (goal_r && scoreCntR != 4'd9) scoreCntR <= scoreCntR + 4'd1;
              if ((goal_l && scoreCntL == 4'd8) || (goal_r && scoreCntR == 4'd8))
                state <= GAME_OVER;
`endif
            end else if (h_fire) begin
              hCol   <= 1'b1;
              h_cool <= COOL_LD;
            end
          end
          default: begin
            serve <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_collision_detector.sv
// tb/tb_ball_collision_detector.sv - directed self-checking bench for ball_collision_detector.
module tb_ball_collision_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] xCoord = 10'd300;
  logic [8:0] yCoord = 9'd200;
  logic [8:0] padLY = 9'd0;
  logic [8:0] padRY = 9'd0;
  logic       vCol, hCol, scoreL, scoreR, serve;
`ifdef SCORE_COUNT_EN
  logic [3:0] scoreCntL, scoreCntR;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ball_collision_detector dut (
    .clk(clk), .reset(reset), .enable(enable),
    .xCoord(xCoord), .yCoord(yCoord), .padLY(padLY), .padRY(padRY),
    .vCol(vCol), .hCol(hCol), .scoreL(scoreL), .scoreR(scoreR), .serve(serve)
`ifdef SCORE_COUNT_EN
    , .scoreCntL(scoreCntL), .scoreCntR(scoreCntR)
`endif
  );

  // pulse vector order: {vCol, hCol, scoreL, scoreR}
  wire [3:0] pulses = {vCol, hCol, scoreL, scoreR};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one enable strobe; returns at the negedge after the sampling edge
  task automatic strobe();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic set_ball(input int xv, input int yv);
    xCoord = 10'(xv);
    yCoord = 9'(yv);
  endtask

  task automatic serve_phase(input string tag);
    for (int i = 1; i <= 60; i++) begin
      strobe();
      check_eq({tag, "_pulses"}, pulses, 0);
      check_eq({tag, "_serve"}, serve, (i < 60) ? 1 : 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_pulses", pulses, 0);
    check_eq("rst_serve", serve, 1);
    reset = 1'b1;

    set_ball(300, 200);
    serve_phase("serve1");
    repeat (3) @(negedge clk);
    check_eq("idle_hold_serve", serve, 0);
    check_eq("idle_hold_pulses", pulses, 0);

    // wall cooldown: fire, three suppressed ticks, fire again
    set_ball(300, 0);
    strobe();
    check_eq("wall1", pulses, 4'b1000);
    @(negedge clk);
    check_eq("wall1_one_clk", vCol, 0);
    for (int i = 0; i < 3; i++) begin
      strobe();
      check_eq("wall_cool", pulses, 0);
    end
    strobe();
    check_eq("wall_refire", pulses, 4'b1000);

    // left paddle hit and miss
    set_ball(24, 100);
    padLY = 9'd80;
    strobe();
    check_eq("padl_hit", pulses, 4'b0100);
    set_ball(300, 471);
    for (int i = 0; i < 4; i++) begin
      strobe();
      check_eq("y471_no_wall", pulses, 0);
    end
    set_ball(24, 100);
    padLY = 9'd200;
    strobe();
    check_eq("padl_miss", pulses, 0);

    // corner: floor and right paddle on the same edge
    set_ball(616, 472);
    padRY = 9'd440;
    strobe();
    check_eq("corner", pulses, 4'b1100);
    set_ball(300, 200);
    repeat (4) strobe();
    set_ball(300, 500);
    strobe();
    check_eq("y_clamped_wall", pulses, 4'b1000);
    set_ball(300, 200);
    repeat (4) strobe();

    // right player scores; serve rises on the same edge
    set_ball(0, 300);
    padLY = 9'd0;
    strobe();
    check_eq("goal_r", pulses, 4'b0001);
    check_eq("goal_r_serve", serve, 1);
    @(negedge clk);
    check_eq("goal_r_one_clk", scoreR, 0);
    serve_phase("serve2");

    // left player scores on a clamped x beyond the field
    set_ball(700, 200);
    padRY = 9'd0;
    strobe();
    check_eq("goal_l_clamped", pulses, 4'b0010);
    check_eq("goal_l_serve", serve, 1);
    set_ball(300, 0);
    serve_phase("serve3");

    // reset asserted while vCol is high
    strobe();
    check_eq("pre_rst_vcol", vCol, 1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_pulses", pulses, 0);
    check_eq("midrst_serve", serve, 1);
    reset = 1'b1;
    strobe();
    check_eq("post_rst_in_serve", pulses, 0);
    check_eq("post_rst_serve", serve, 1);

`ifdef SCORE_COUNT_EN
    reset = 1'b0;
    @(negedge clk);
    check_eq("cnt_rst_r", scoreCntR, 0);
    check_eq("cnt_rst_l", scoreCntL, 0);
    reset = 1'b1;
    set_ball(300, 200);
    serve_phase("cnt_serve0");
    for (int k = 1; k <= 9; k++) begin
      set_ball(0, 200);
      strobe();
      check_eq("cnt_goal", scoreR, 1);
      check_eq("cnt_val", scoreCntR, k);
      if (k < 9) serve_phase("cnt_serve");
    end
    set_ball(0, 0);
    for (int i = 0; i < 70; i++) begin
      strobe();
      check_eq("gameover_pulses", pulses, 0);
      check_eq("gameover_serve", serve, 1);
    end
    check_eq("gameover_cnt", scoreCntR, 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
